// File: rtl/calc_engine.sv
// Pair-wise arithmetic engine: clears its memory, then on each pass reads word pairs
// (A,B) and emits sum, |difference|, product and restoring-division quotient/remainder.
module calc_engine #(
  parameter int W     = 16,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              term_zero,
  output logic [AW-1:0]     count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-2:0]     out_idx,
  output logic [W-1:0]      out_a,
  output logic [W-1:0]      out_b,
  output logic [W:0]        out_sum,
  output logic [W-1:0]      out_diff,
  output logic [2*W-1:0]    out_prod,
  output logic [W-1:0]      out_quot,
  output logic [W-1:0]      out_rem
);

  localparam int CW = $clog2(W + 1);
  localparam logic [AW-1:0] LAST_K    = AW'(DEPTH / 2 - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, FETCH, DIVIDE, OUTPUT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   clr_ptr;
  logic [AW-1:0]   k;
  logic [W-1:0]    a, b, q, r;
  logic [CW-1:0]   step;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    rd_a, rd_b;
  logic [W:0]      trial, trial_sub;
  logic [W-1:0]    q_nxt, r_nxt;

  always_comb begin
    mem_we    = !reset && (state == CLEAR || (state == IDLE && wr_en));
    mem_waddr = (state == CLEAR) ? clr_ptr : wr_addr;
    mem_wdata = (state == CLEAR) ? '0 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign rd_a = mem[{k[AW-2:0], 1'b0}];
  assign rd_b = mem[{k[AW-2:0], 1'b1}];

  // One restoring step: shift next dividend bit into the partial remainder, keep the
  // subtraction only when it does not borrow.
  always_comb begin
    trial     = {r, q[W-1]};
    trial_sub = trial - {1'b0, b};
    if (trial_sub[W]) begin
      r_nxt = trial[W-1:0];
      q_nxt = {q[W-2:0], 1'b0};
    end else begin
      r_nxt = trial_sub[W-1:0];
      q_nxt = {q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      k         <= '0;
      a         <= '0;
      b         <= '0;
      q         <= '0;
      r         <= '0;
      step      <= '0;
      ready     <= 1'b0;
      done      <= 1'b0;
      term_zero <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
      out_diff  <= '0;
      out_prod  <= '0;
      out_quot  <= '0;
      out_rem   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            ready     <= 1'b0;
            k         <= '0;
            count     <= '0;
            term_zero <= 1'b0;
          end
        end
        FETCH: begin
          a <= rd_a;
          b <= rd_b;
          if (rd_b == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            term_zero <= 1'b1;
          end else begin
            state <= DIVIDE;
            q     <= rd_a;
            r     <= '0;
            step  <= '0;
          end
        end
        DIVIDE: begin
          q    <= q_nxt;
          r    <= r_nxt;
          step <= step + 1'b1;
          if (step == LAST_STEP)
            state <= OUTPUT;
        end
        OUTPUT: begin
          // First OUTPUT cycle registers the result fields; later cycles wait for the handshake.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_idx   <= k[AW-2:0];
            out_a     <= a;
            out_b     <= b;
            out_sum   <= {1'b0, a} + {1'b0, b};
            out_diff  <= (a >= b) ? a - b : b - a;
            out_prod  <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
            out_quot  <= q;
            out_rem   <= r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            count     <= count + 1'b1;
            k         <= k + 1'b1;
            if (k == LAST_K) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
